// File: rtl/serial_add_pkg.sv
// Shared types and constants for the two-bit-per-clock serial adder.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sas_state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit ripple-carry slice: {co, s} = x + y + ci.
module add2_slice
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic c1;

  assign s[0] = x[0] ^ y[0] ^ ci;
  assign c1   = (x[0] & y[0]) | (x[0] & ci) | (y[0] & ci);
  assign s[1] = x[1] ^ y[1] ^ c1;
  assign co   = (x[1] & y[1]) | (x[1] & c1) | (y[1] & c1);

endmodule

// File: rtl/serial_add_seq.sv
// Serial adder: WIDTH-bit add stepped LSB-first through one 2-bit slice, valid/ready on both sides.
// Optional macro SERIAL_ADD_CIN_EN adds a cin port that preloads the carry at accept.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS  = WIDTH / SLICE_W;
  localparam int STEP_W = $clog2(STEPS) + 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_add_seq: WIDTH must be even and >= 2");
  end

  sas_state_e          state, next_state;
  logic [WIDTH-1:0]    op_a, op_b, res_sh, res_next;
  logic                carry, carry_init;
  logic [STEP_W-1:0]   step;
  logic [SLICE_W-1:0]  slice_s;
  logic                slice_co;
  logic                accept, last_step;

`ifdef SERIAL_ADD_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  add2_slice u_slice (
    .x  (op_a[SLICE_W-1:0]),
    .y  (op_b[SLICE_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each slice result enters at the top, so after the last step the full sum is aligned.
  assign res_next  = (res_sh >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
  assign accept    = in_valid & in_ready;
  assign last_step = (step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_step) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // sum/cout only update on the final step so the previous result stays visible until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      step   <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= carry_init;
      step  <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> SLICE_W;
      op_b   <= op_b >> SLICE_W;
      res_sh <= res_next;
      carry  <= slice_co;
      step   <= step + STEP_W'(1);
      if (last_step) begin
        sum  <= res_next;
        cout <= slice_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed scoreboard bench for serial_add_seq (WIDTH=8 main instance, plus WIDTH=2 and WIDTH=16).
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, cin;
  logic [7:0] a, b;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum;

  logic        w2_in_valid, w2_in_ready, w2_out_valid, w2_cout;
  logic [1:0]  w2_a, w2_b, w2_sum;
  logic        w16_in_valid, w16_in_ready, w16_out_valid, w16_cout;
  logic [15:0] w16_a, w16_b, w16_sum;

  int passed = 0;
  int total  = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef SERIAL_ADD_CIN_EN
    .cin(cin),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  serial_add_seq #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
    .a(w2_a), .b(w2_b),
`ifdef SERIAL_ADD_CIN_EN
    .cin(1'b0),
`endif
    .out_valid(w2_out_valid), .out_ready(1'b1), .sum(w2_sum), .cout(w2_cout)
  );

  serial_add_seq #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .a(w16_a), .b(w16_b),
`ifdef SERIAL_ADD_CIN_EN
    .cin(1'b0),
`endif
    .out_valid(w16_out_valid), .out_ready(1'b1), .sum(w16_sum), .cout(w16_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one operand pair; returns on the falling edge right after the accept edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int n = 0;
    logic cin_eff;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
`ifdef SERIAL_ADD_CIN_EN
    cin_eff = cv;
`else
    cin_eff = 1'b0;
`endif
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    sb_q.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cin_eff});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency against exp_lat, then compares with the scoreboard head.
  task automatic checkOutput(input string tag, input int exp_lat);
    int n = 0;
    logic [8:0] exp;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    exp = sb_q.pop_front();
    check({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[8]));
  endtask

  initial begin
    int n;
    logic [7:0] held_sum;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; a = '0; b = '0;
    w2_in_valid = 1'b0; w2_a = '0; w2_b = '0;
    w16_in_valid = 1'b0; w16_a = '0; w16_b = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: simple carry into bit 4, latency 4
    applyStimulus(8'h0F, 8'h01, 1'b0);
    checkOutput("t1", 4);
    @(negedge clk);
    check("t1_back_idle", 32'(in_ready), 32'd1);
    check("t1_sum_held", 32'(sum), 32'h10);

    // 2: carry ripples through every step
    applyStimulus(8'hFF, 8'h01, 1'b0);
    checkOutput("t2", 4);
    @(negedge clk);

    // 3: consumer stalls for 5 clocks
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0);
    checkOutput("t3", 4);
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_valid", 32'(out_valid), 32'd1);
      check("t3_stall_ready", 32'(in_ready), 32'd0);
      check("t3_stall_sum", 32'(sum), 32'(held_sum));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_idle_ready", 32'(in_ready), 32'd1);
    check("t3_idle_valid", 32'(out_valid), 32'd0);

    // 4: reset in the middle of RUN (step 2)
    applyStimulus(8'h77, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_ready", 32'(in_ready), 32'd1);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_no_result", 32'(out_valid), 32'd0);
    applyStimulus(8'h55, 8'hAA, 1'b0);
    checkOutput("t4", 4);
    @(negedge clk);

    // 5: operands keep changing while busy; only the accepted pair counts
    applyStimulus(8'h3C, 8'h5A, 1'b0);
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checkOutput("t5", 0);
    check("t5_latency_total", 32'(n), 32'd4);
    @(negedge clk);

    // 6: carry-in preload (cin only matters when the macro is built in)
    applyStimulus(8'hFF, 8'h00, 1'b1);
    checkOutput("t6", 4);
    @(negedge clk);
    cin = 1'b0;

    // WIDTH=2: single step
    w2_in_valid = 1'b1; w2_a = 2'b11; w2_b = 2'b01;
    @(negedge clk);
    w2_in_valid = 1'b0;
    n = 0;
    while (!w2_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w2_latency", 32'(n), 32'd1);
    check("w2_sum", 32'(w2_sum), 32'd0);
    check("w2_cout", 32'(w2_cout), 32'd1);

    // WIDTH=16: eight steps
    @(negedge clk);
    w16_in_valid = 1'b1; w16_a = 16'hFFFF; w16_b = 16'h0001;
    @(negedge clk);
    w16_in_valid = 1'b0;
    n = 0;
    while (!w16_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w16_latency", 32'(n), 32'd8);
    check("w16_sum", 32'(w16_sum), 32'h0000);
    check("w16_cout", 32'(w16_cout), 32'd1);
    @(negedge clk);

    w16_in_valid = 1'b1; w16_a = 16'h1234; w16_b = 16'h4321;
    @(negedge clk);
    w16_in_valid = 1'b0;
    n = 0;
    while (!w16_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w16b_sum", 32'(w16_sum), 32'h5555);
    check("w16b_cout", 32'(w16_cout), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
